// File: rtl/dual_lane_mult_checker_pkg.sv
// Shared types and sizing helpers for the dual-lane multiplier checker.
// Optional macro DLMC_SIGNED_EN switches both lanes to two's complement operands.
package dlmc_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int DLMC_W = 32;
  // Lane B iteration counter width for the default operand width.
  localparam int ITER_W = $clog2(DLMC_W + 1);

  function automatic int lat_done(input int lat, input int w);
    return (lat > w) ? lat : w;
  endfunction

endpackage

// File: rtl/dual_lane_mult_checker_if.sv
// Operand load, job launch and result handshake bundle of the dual-lane checker.
// master drives operands/start/res_ready; slave is the checker itself.
interface dual_lane_mult_checker_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic             ld_a;
  logic [W-1:0]     a_in;
  logic             ld_b;
  logic [W-1:0]     b_in;
  logic             start;
  logic             busy;
  logic             res_valid;
  logic [2*W-1:0]   res;
  logic             res_ready;
  logic             mismatch;
  logic [CNT_W-1:0] job_cnt;

  modport master (
    output ld_a, a_in, ld_b, b_in, start, res_ready,
    input  busy, res_valid, res, mismatch, job_cnt
  );

  modport slave (
    input  ld_a, a_in, ld_b, b_in, start, res_ready,
    output busy, res_valid, res, mismatch, job_cnt
  );
endinterface

// File: rtl/dual_lane_mult_checker_shift_add_mult.sv
// Lane B: iterative shift-add multiplier, one multiplier bit per cycle, done W cycles after go.
// With DLMC_SIGNED_EN it multiplies magnitudes and negates when operand signs differ.
module shift_add_mult
  import dlmc_pkg::*;
#(
  parameter int W  = DLMC_W,
  parameter int IW = ITER_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] ma;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mb;
  logic [IW-1:0]  iter;
  logic           running;
  logic           have;

`ifdef DLMC_SIGNED_EN
  logic neg_q;

  // -MIN wraps to MIN, which is still the correct unsigned magnitude.
  assign mag_a = a[W-1] ? -a : a;
  assign mag_b = b[W-1] ? -b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (go) begin
      neg_q <= a[W-1] ^ b[W-1];
    end
  end

  assign prod = neg_q ? -acc : acc;
`else
  assign mag_a = a;
  assign mag_b = b;
  assign prod  = acc;
`endif

  // Iteration 0 is folded into the go edge so the product is ready after W-1 further edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      ma      <= '0;
      mb      <= '0;
      iter    <= '0;
      running <= 1'b0;
      have    <= 1'b0;
    end else if (go) begin
      acc     <= mag_b[0] ? {{W{1'b0}}, mag_a} : '0;
      ma      <= {{W{1'b0}}, mag_a} << 1;
      mb      <= mag_b >> 1;
      iter    <= IW'(1);
      running <= (W > 1);
      have    <= 1'b1;
    end else if (running) begin
      acc  <= acc + (mb[0] ? ma : '0);
      ma   <= ma << 1;
      mb   <= mb >> 1;
      iter <= iter + IW'(1);
      if (iter == IW'(W - 1)) begin
        running <= 1'b0;
      end
    end
  end

  assign done = have & ~running;

endmodule

// File: rtl/dual_lane_mult_checker.sv
// Two-lane multiplier (pipelined array lane A, shift-add lane B) run in lockstep, result on valid/ready.
// Sticky mismatch flags any lane disagreement; macro DLMC_SIGNED_EN selects signed operands.
module dual_lane_mult_checker
  import dlmc_pkg::*;
#(
  parameter int W     = 32,
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_lane_mult_checker_if.slave bus
);

  localparam int LD   = lat_done(LAT, W);
  localparam int BC_W = $clog2(LD + 1);

  state_t           state_q;
  state_t           state_d;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     ja;
  logic [W-1:0]     jb;
  logic [BC_W-1:0]  bcnt;
  logic [2*W-1:0]   res_q;
  logic [CNT_W-1:0] job_cnt_q;
  logic             mismatch_q;
  logic [2*W-1:0]   stage0;
  logic [2*W-1:0]   prod_a;
  logic [2*W-1:0]   prod_b;
  logic             b_done;
  logic             go;
  logic             busy_end;

  assign go       = (state_q == IDLE) && bus.start;
  assign busy_end = (bcnt == BC_W'(LD - 1)) && b_done;

`ifdef DLMC_SIGNED_EN
  logic [2*W-1:0] ext_a;
  logic [2*W-1:0] ext_b;

  // Low 2W bits of the product of sign-extended operands equal the signed product.
  assign ext_a  = {{W{ja[W-1]}}, ja};
  assign ext_b  = {{W{jb[W-1]}}, jb};
  assign stage0 = ext_a * ext_b;
`else
  assign stage0 = {{W{1'b0}}, ja} * {{W{1'b0}}, jb};
`endif

  generate
    if (LAT > 1) begin : g_pipe
      logic [2*W-1:0] pipe [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LAT - 1; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= stage0;
          for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
      end

      assign prod_a = pipe[LAT-2];
    end else begin : g_comb
      assign prod_a = stage0;
    end
  endgenerate

  shift_add_mult #(
    .W  (W),
    .IW ($clog2(W + 1))
  ) u_lane_b (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .a    (opa),
    .b    (opb),
    .done (b_done),
    .prod (prod_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY:    if (busy_end) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa        <= '0;
      opb        <= '0;
      ja         <= '0;
      jb         <= '0;
      bcnt       <= '0;
      res_q      <= '0;
      job_cnt_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bcnt <= '0;
          // Job registers take the pre-edge operands; a same-cycle load is kept for the next job.
          if (bus.start) begin
            ja <= opa;
            jb <= opb;
          end
          if (bus.ld_a) opa <= bus.a_in;
          if (bus.ld_b) opb <= bus.b_in;
        end
        BUSY: begin
          bcnt <= bcnt + BC_W'(1);
          if (busy_end) begin
            res_q <= prod_a;
            if (prod_a != prod_b) mismatch_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) job_cnt_q <= job_cnt_q + CNT_W'(1);
        end
        default: bcnt <= '0;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.job_cnt   = job_cnt_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: doc/dual_lane_mult_checker.md
Name: dual_lane_mult_checker

Overview:
- Parametrised successor of the two-path multiplier equivalence block. Lane A is a LAT-stage pipelined array multiplier. Lane B is an iterative shift-add multiplier producing one bit per cycle.
- Both lanes compute the same job in lockstep. The result is handed out on a valid/ready port, and a sticky flag records any lane disagreement.
- Used as a datapath unit and as a model-checking target; the invariant is that mismatch never rises.

Parameters:
- W, 32, operand width; result width is 2*W.
- LAT, 3, lane A pipeline depth in cycles; legal range 1..8.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_a  in  1  load operand A register from a_in.
- a_in  in  W  operand A data.
- ld_b  in  1  load operand B register from b_in.
- b_in  in  W  operand B data.
- start  in  1  launch a job from the current operand registers.
- busy  out  1  high while state is BUSY or DONE.
- res_valid  out  1  result available.
- res  out  2W  product from lane A.
- res_ready  in  1  consumer accepts res.
- mismatch  out  1  sticky; lane A != lane B on some completed job.
- job_cnt  out  CNT_W  count of accepted results.

Behaviour:
- Reset (async, active-high): state IDLE; opa, opb, res, job_cnt = 0; res_valid, busy, mismatch = 0; both lanes cleared.
- Reset asserted mid-job aborts the job; no partial result is ever presented.
- FSM states:
  - IDLE: ld_a/ld_b update opa/opb on the clock edge. start moves to BUSY and captures opa/opb into job registers ja/jb. If start and ld_x occur in the same cycle, the job uses the pre-edge opa/opb, and the new value is kept for the next job.
  - BUSY: lane A forms ja*jb in stage 0 and shifts it through LAT-1 registers, so prodA is valid LAT cycles after start. Lane B examines bit i of jb in iteration i, adding ja<<i to its accumulator; prodB is valid after W cycles. Leave BUSY when both lanes are done, i.e. max(LAT, W) cycles after the start edge. Defaults give 32 cycles.
  - DONE: res_valid=1 and res=prodA, both held stable until the edge where res_ready=1. mismatch is set on entry to DONE if prodA != prodB. On acceptance: job_cnt+1 (wraps modulo 2^CNT_W), go to IDLE, res_valid=0. res keeps its last value.
- start, ld_a and ld_b are ignored in BUSY and DONE.
- A new start can be accepted at the earliest one cycle after acceptance, since acceptance returns to IDLE.
- Arithmetic is unsigned by default and exact in 2W bits; no truncation.
- mismatch is cleared only by rst.

Optional Feature:
- Macro: DLMC_SIGNED_EN.
- Defined: operands are two's complement, and res is the signed 2W-bit product. Lane A multiplies sign-extended operands. Lane B multiplies magnitudes and negates the result when the operand signs differ. The most negative value times the most negative value must be exact (positive 2^(2W-2)).
- Undefined: unsigned only, and no sign logic is synthesised.

Decomposition:
- Shared package dlmc_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Function lat_done = max(LAT, W).
  - Localparam for the lane B iteration counter width, $clog2(W+1).
- Sub-module shift_add_mult: lane B. Its interface is clk, rst, go, a, b, done, prod, and it is parametrised on W and the signed macro. Lane A stays inline.

Test Plan:
- Reset defaults: assert rst mid-BUSY -> all outputs 0 within the same cycle; after release, the next job computes normally.
- Ones squared: W=32, load 0xFFFFFFFF into A and B, start -> busy for 32 cycles, then res_valid=1, res=0xFFFFFFFE00000001, mismatch=0.
- Same-cycle load and start: in IDLE, opa=3, opb=5; pulse start with ld_a=1, a_in=7 -> res=15. The next job gives 35.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res stable, start ignored, job_cnt unchanged. Then res_ready=1 -> job_cnt+1, busy=0 next cycle.
- Counter wrap: CNT_W=2, complete 5 jobs -> job_cnt=1. With LAT=8, W=4: busy lasts 8 cycles and 9*13=117.
- DLMC_SIGNED_EN: W=8, A=0x80, B=0x80 -> res=0x4000. A=0xFF, B=0x02 -> res=0xFFFE. mismatch=0 throughout.
